// File: rtl/inputdata_source_if.sv
// inputdata_source_if: serial input, consumer handshake and status signals
// of the inputdata_source producer.
// Optional macro: INPUTDATA_PARITY_EN adds the parity_err status line.
interface inputdata_source_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclr;
    logic                  sdata_in;
    logic                  sdata_valid;
    logic                  loaddata;
    logic                  inputdata_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  overrun;
`ifdef INPUTDATA_PARITY_EN
    logic                  parity_err;
`endif

    // Producer side (the deserializer)
    modport master (
        input  sclr,
        input  sdata_in,
        input  sdata_valid,
        input  loaddata,
        output inputdata_ready,
        output data_out,
`ifdef INPUTDATA_PARITY_EN
        output parity_err,
`endif
        output overrun
    );

    // Consumer side (front end plus control unit)
    modport slave (
        output sclr,
        output sdata_in,
        output sdata_valid,
        output loaddata,
        input  inputdata_ready,
        input  data_out,
`ifdef INPUTDATA_PARITY_EN
        input  parity_err,
`endif
        input  overrun
    );
endinterface

// File: rtl/inputdata_source.sv
// inputdata_source: deserializes an MSB-first bit stream into DATA_WIDTH-bit
// words and offers each completed word to the control unit through the
// inputdata_ready / loaddata handshake.
// Optional macro: INPUTDATA_PARITY_EN -- an even-parity bit follows every
// word; a bad word is dropped and parity_err pulses for one cycle.
module inputdata_source #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    inputdata_source_if.master bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] COLLECT = 2'd0;
`ifdef INPUTDATA_PARITY_EN
    localparam logic [1:0] PARITY  = 2'd1;
`endif
    localparam logic [1:0] READY   = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  overrun_q;
    logic                  last_bit;
`ifdef INPUTDATA_PARITY_EN
    logic                  parity_err_q;
`endif

    assign shift_next = {shift_reg[DATA_WIDTH-2:0], bus.sdata_in};
    assign last_bit   = (bit_cnt == CW'(DATA_WIDTH - 1));

    // Bit collection, word hand-off and status tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= COLLECT;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            data_q       <= '0;
            overrun_q    <= 1'b0;
`ifdef INPUTDATA_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
`ifdef INPUTDATA_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (bus.sclr) begin
                // Abort the word in flight; data_out keeps the last good word
                state     <= COLLECT;
                bit_cnt   <= '0;
                shift_reg <= '0;
                overrun_q <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (bus.sdata_valid) begin
                            shift_reg <= shift_next;
                            if (last_bit) begin
                                bit_cnt <= '0;
`ifdef INPUTDATA_PARITY_EN
                                state   <= PARITY;
`else
                                data_q  <= shift_next;
                                state   <= READY;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
`ifdef INPUTDATA_PARITY_EN
                    PARITY: begin
                        // shift_reg holds the finished word while the parity bit is awaited
                        if (bus.sdata_valid) begin
                            if ((^shift_reg ^ bus.sdata_in) == 1'b0) begin
                                data_q <= shift_reg;
                                state  <= READY;
                            end else begin
                                parity_err_q <= 1'b1;
                                state        <= COLLECT;
                            end
                        end
                    end
`endif
                    READY: begin
                        if (bus.loaddata) begin
                            state <= COLLECT;
                            // A bit arriving with the acknowledge starts the next word
                            if (bus.sdata_valid) begin
                                shift_reg <= shift_next;
                                bit_cnt   <= CW'(1);
                            end
                        end else if (bus.sdata_valid) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

    assign bus.inputdata_ready = (state == READY);
    assign bus.data_out        = data_q;
    assign bus.overrun         = overrun_q;
`ifdef INPUTDATA_PARITY_EN
    assign bus.parity_err      = parity_err_q;
`endif
endmodule

// File: doc/inputdata_source.md
Name: inputdata_source

Overview:
- Producer end of the `inputdata_ready`/`loaddata` handshake; the control unit is the consumer.
- Deserializes a bit-serial stream (MSB first, one bit per `sdata_valid` strobe) into a `DATA_WIDTH` word.
- Raises `inputdata_ready` with the word held stable on `data_out` until the control unit answers with `loaddata`.
- Sits between the board-level serial/switch front end and the control unit/datapath.

Parameters:
- DATA_WIDTH, 8: word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sclr  input  1  synchronous clear: abort the current word and clear `overrun`.
- sdata_in  input  1  serial data bit.
- sdata_valid  input  1  `sdata_in` is sampled on this cycle.
- loaddata  input  1  consumer acknowledge; honoured only while `inputdata_ready`=1.
- inputdata_ready  output  1  `data_out` holds a complete, unconsumed word.
- data_out  output  DATA_WIDTH  last completed word.
- overrun  output  1  sticky: a bit arrived while a word was pending.
- parity_err  output  1  one-cycle pulse; present only with `INPUTDATA_PARITY_EN`.

Behaviour:
- Reset (reset=0, async):
  - state=COLLECT, bit_cnt=0, shift register=0.
  - `data_out`=0, `inputdata_ready`=0, `overrun`=0, `parity_err`=0.
- States: COLLECT, PARITY (with macro only), READY.
- COLLECT:
  - On `sdata_valid`=1: shift_reg <= {shift_reg[DATA_WIDTH-2:0], sdata_in}; bit_cnt++.
  - `bit_cnt` is $clog2(DATA_WIDTH+1) bits wide.
  - When the DATA_WIDTH-th bit is accepted, in the same edge:
    - `data_out` <= completed word (the accepted bit is the LSB).
    - bit_cnt <= 0; next state READY.
    - Without macro: `inputdata_ready`=1 on the next cycle (latency 1 clk from last bit).
- READY:
  - `inputdata_ready`=1; `data_out` held.
  - `loaddata`=1: next cycle `inputdata_ready`=0, state COLLECT.
  - Simultaneous `sdata_valid`=1 with `loaddata`=1: the bit is accepted as MSB (bit 1) of the next word. Zero-bubble back-to-back operation is allowed.
  - `sdata_valid`=1 without `loaddata`: the bit is dropped, `overrun` <= 1, state unchanged, `data_out` unchanged.
- `loaddata` while not in READY: ignored, no effect.
- `data_out` is not cleared after the handshake; it changes only when a new word completes.
- `sclr`=1 (highest priority after reset), in any state:
  - bit_cnt=0, state=COLLECT, `inputdata_ready`=0, `overrun`=0.
  - `data_out` is retained.
  - Bits and `loaddata` in the `sclr` cycle are ignored.
- `overrun` is cleared only by reset or `sclr`.
- Reset asserted mid-word or in READY: the partial or pending word is discarded and all outputs return to reset values immediately (async).

Optional Feature:
- Macro: `INPUTDATA_PARITY_EN`.
- With macro defined:
  - After the DATA_WIDTH-th bit, go to PARITY (`data_out` not yet updated).
  - The next accepted bit is an even-parity bit: XOR of data bits and parity bit must be 0.
  - Match: `data_out` <= word, go to READY; `inputdata_ready`=1 one cycle after the parity bit.
  - Mismatch: word discarded, `parity_err`=1 for exactly one cycle, return to COLLECT, `data_out` unchanged, `inputdata_ready` stays 0.
  - `sclr` in PARITY aborts the word without a `parity_err` pulse.
- Without macro: no PARITY state, no `parity_err` port; behaviour as above.

Test Plan:
- Reset release, then 8 valid bits 1,0,1,0,0,1,0,1 back-to-back -> `inputdata_ready`=1 one cycle after the 8th bit, `data_out`=0xA5, `overrun`=0.
- Word 0x3C pending, `loaddata` pulse 1 clk -> `inputdata_ready`=0 next cycle, `data_out` stays 0x3C; a second `loaddata` while not ready has no effect.
- Word 0xFF pending, 2 valid bits without `loaddata` -> `overrun`=1, `data_out`=0xFF, `inputdata_ready`=1; `sclr` pulse -> `overrun`=0, `inputdata_ready`=0.
- Word pending, `loaddata` and `sdata_valid`(1) in the same cycle, then 7 more bits 0000001 -> next word `data_out`=0x81, ready asserted after the 7th extra bit.
- 4 bits sent, reset pulled low mid-word, then 8 bits of 0x5A -> `data_out`=0x5A (no leftover bits), ready asserted normally.
- With `INPUTDATA_PARITY_EN`: 0xA5 plus parity 0 -> ready, `data_out`=0xA5; 0xA5 plus parity 1 -> `parity_err` one-cycle pulse, `inputdata_ready`=0, `data_out` unchanged.
